midi_tx: RTL and testbench
==========================

MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 800, SHALL set clock cycles per serial bit (800 = 31250 baud at 25 MHz); legal values 2..65535.
REQ-002 Parameter DEPTH, default 4, SHALL set byte FIFO depth; legal values are powers of two, 2..16.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 wr  input  1  SHALL be the write strobe from the CPU output-port register; it is sampled on each rising edge.
REQ-006 din  input  8  SHALL be the MIDI byte written when wr=1.
REQ-007 tx  output  1  SHALL be the serial MIDI line: 8N1, LSB first, idle high.
REQ-008 full  output  1  SHALL be 1 when the FIFO holds DEPTH bytes.
REQ-009 busy  output  1  SHALL be 1 when the FIFO is non-empty or a frame is in progress.
REQ-010 overflow  output  1  SHALL be a sticky flag, set when a write is dropped.

Function
REQ-011 FIFO: circular buffer, DEPTH entries, with read and write pointers and a 0..DEPTH count; pointers SHALL wrap from DEPTH-1 to 0.
REQ-012 A write SHALL be accepted when wr=1 and (count<DEPTH, or a pop occurs in the same cycle); otherwise the byte SHALL be dropped and overflow set to 1.
REQ-013 Simultaneous accepted write and pop SHALL leave count unchanged; there SHALL be no bypass from din to the shifter.
REQ-014 States: IDLE, START, DATA, STOP; each bit lasts exactly CLKS_PER_BIT cycles, timed by a 16-bit baud counter.
REQ-015 IDLE: tx=1; if count>0, SHALL pop the head byte into the 8-bit shift register, clear the baud counter and the 3-bit bit index, and go to START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA: tx=shift[0]; at each bit end SHALL shift right and increment the bit index; after bit 7 it SHALL go to STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 Latency: a byte written into an empty idle FIFO at edge N SHALL be popped at edge N+1, with tx falling after edge N+1.
REQ-020 Back-to-back frames SHALL be separated by exactly one IDLE cycle (tx=1), so each frame period is 10*CLKS_PER_BIT+1 cycles.
REQ-021 tx SHALL be a registered output with no combinational path from wr or din.
REQ-022 busy SHALL be (state!=IDLE) or (count>0), driven combinationally from registers.
REQ-023 overflow SHALL clear only on reset.

Reset
REQ-024 With reset=0, the block SHALL immediately and asynchronously set tx=1, state=IDLE, count=0, both pointers=0, baud counter=0, bit index=0, overflow=0, full=0 and busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; the first frame after reset release SHALL be well formed.
REQ-026 FIFO storage contents need not be reset.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-027 Single byte: write 0x90 into an idle block -> tx low 4 cycles, then data bits 0,0,0,0,1,0,0,1 at 4 cycles each, then high 4 cycles; busy falls 41 cycles after the write edge.
REQ-028 Burst: write 0x90, 0x3C, 0x64 on consecutive cycles -> three frames with falling edges 41 cycles apart; full never asserts; overflow stays 0.
REQ-029 Overflow: write 6 bytes on consecutive cycles -> the first byte is popped, the next 4 are held (full=1), the 6th is dropped with overflow=1; exactly 5 frames are transmitted.
REQ-030 Full with simultaneous pop: FIFO full with the transmitter entering IDLE, wr=1 on the pop cycle -> write accepted, count stays 4, overflow stays 0.
REQ-031 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately with busy=0; after release, write 0xFF -> one clean frame.
REQ-032 Idle line: no writes for 100 cycles after reset -> tx=1, busy=0, full=0 throughout.

Source files
------------

// File: rtl/midi_tx_if.sv
// CPU-side port of the MIDI transmitter: write strobe/byte in, FIFO and line status out.
// No handshake; a write while full (without a same-cycle pop) is dropped and flagged.
interface midi_tx_if;
  logic       wr;
  logic [7:0] din;
  logic       full;
  logic       busy;
  logic       overflow;

  modport master (output wr, din, input full, busy, overflow);
  modport slave  (input wr, din, output full, busy, overflow);
endinterface

// File: rtl/midi_tx.sv
// 8N1 MIDI serialiser behind a DEPTH-entry byte FIFO; tx falls the edge after a write into an empty idle block.
// No backpressure: a write into a full FIFO is dropped unless the shifter pops that same cycle; overflow is sticky.
module midi_tx #(
  parameter int CLKS_PER_BIT = 800,
  parameter int DEPTH        = 4
) (
  input  logic          clk,
  input  logic          reset,
  midi_tx_if.slave      cpu,
  output logic          tx
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [15:0]   baud, baud_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          pop, push, bit_end;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  assign bit_end = (baud == BAUD_LAST);
  // A pop frees a slot in the same cycle, so a full FIFO can still take a write then.
  assign push    = cpu.wr && ((count < DEPTH_C) || pop);

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt    = '0;
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is decided from next state so tx itself can be a flop.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (cpu.wr && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cpu.din;
  end

  assign cpu.full     = (count == DEPTH_C);
  assign cpu.busy     = (state != IDLE) || (count != '0);
  assign cpu.overflow = overflow;

endmodule

// File: tb/tb_midi_tx.sv
// Scoreboard bench for midi_tx at CLKS_PER_BIT=4, DEPTH=4: writes push expected bytes, a line monitor decodes frames.
module tb_midi_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tx;

  midi_tx_if cpu_if ();

  midi_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .cpu   (cpu_if),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  int last_wr_cyc = 0;
  int frames   = 0;
  bit full_seen = 0;
  logic [7:0] exp_q [$];
  int         fall_q [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line monitor: counts negedges from the first low sample and samples mid-bit.
  int         mon_cnt = 0;
  int         mon_k   = 0;
  bit         mon_act = 0;
  logic       tx_prev = 1'b1;
  logic [7:0] mon_byte = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 0;
      mon_cnt = 0;
      tx_prev = 1'b1;
    end else begin
      if (cpu_if.full) full_seen = 1;
      if (!mon_act) begin
        if (tx_prev && !tx) begin
          mon_act = 1;
          mon_cnt = 1;
          fall_q.push_back(cyc_cnt);
        end
      end else begin
        mon_cnt++;
      end
      if (mon_act && (mon_cnt % CPB) == CPB / 2) begin
        mon_k = mon_cnt / CPB;
        if (mon_k == 0) begin
          chk("start_bit", tx, 0);
        end else if (mon_k <= 8) begin
          mon_byte[mon_k-1] = tx;
        end else begin
          chk("stop_bit", tx, 1);
          frames++;
          chk("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("frame_byte", mon_byte, exp_q.pop_front());
          mon_act = 0;
        end
      end
      tx_prev = tx;
    end
  end

  task automatic do_wr(input logic [7:0] b);
    @(negedge clk);
    cpu_if.wr  = 1'b1;
    cpu_if.din = b;
    @(posedge clk);
    #1;
    last_wr_cyc = cyc_cnt;
    cpu_if.wr   = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc_cnt < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (cpu_if.busy && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_timeout", cpu_if.busy, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_state", {tx, cpu_if.busy, cpu_if.full, cpu_if.overflow}, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, fr0;
    bit idle_bad;
    cpu_if.wr  = 1'b0;
    cpu_if.din = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", {tx, cpu_if.busy, cpu_if.full, cpu_if.overflow}, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet line after reset
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || cpu_if.busy !== 1'b0 || cpu_if.full !== 1'b0) idle_bad = 1;
      if (i % 25 == 0) chk("idle_line", {tx, cpu_if.busy, cpu_if.full}, 3'b100);
    end
    chk("idle_all_cycles", idle_bad, 0);

    // Single byte: start fall one edge after write, busy drops 41 edges after write
    fall_q.delete();
    exp_q.push_back(8'h90);
    do_wr(8'h90);
    w = last_wr_cyc;
    chk("single_busy_after_wr", cpu_if.busy, 1);
    drain();
    chk("single_frames_seen", fall_q.size(), 1);
    if (fall_q.size() > 0) chk("single_first_fall", fall_q[0] - w, 1);

    // Busy-fall timing measured directly
    exp_q.push_back(8'h90);
    do_wr(8'h90);
    w = last_wr_cyc;
    for (int t = 0; t < 200 && cpu_if.busy; t++) begin
      @(posedge clk);
      #1;
    end
    chk("single_busy_fall", cyc_cnt - w, 41);
    drain();

    // Burst of three
    fall_q.delete();
    full_seen = 0;
    fr0 = frames;
    exp_q.push_back(8'h90); do_wr(8'h90);
    exp_q.push_back(8'h3C); do_wr(8'h3C);
    exp_q.push_back(8'h64); do_wr(8'h64);
    drain();
    chk("burst_frames", frames - fr0, 3);
    chk("burst_falls", fall_q.size(), 3);
    if (fall_q.size() == 3) begin
      chk("burst_gap1", fall_q[1] - fall_q[0], 41);
      chk("burst_gap2", fall_q[2] - fall_q[1], 41);
    end
    chk("burst_no_full", full_seen, 0);
    chk("burst_no_ovf", cpu_if.overflow, 0);

    // Overflow: six writes, first popped, four held, sixth dropped
    fr0 = frames;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'h11 + 8'(i));
      do_wr(8'h11 + 8'(i));
      if (i == 4) chk("ovf_full_before", {cpu_if.full, cpu_if.overflow}, 2'b10);
    end
    chk("ovf_after_drop", {cpu_if.full, cpu_if.overflow}, 2'b11);
    drain();
    chk("ovf_frames", frames - fr0, 5);
    chk("ovf_sticky", cpu_if.overflow, 1);

    // Full FIFO with a write on the pop cycle
    apply_reset();
    chk("ovf_cleared", cpu_if.overflow, 0);
    fall_q.delete();
    fr0 = frames;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h21 + 8'(i));
      do_wr(8'h21 + 8'(i));
      if (i == 0) w = last_wr_cyc;
    end
    chk("fp_full", cpu_if.full, 1);
    wait_cyc(w + 41);
    chk("fp_full_pre_pop", cpu_if.full, 1);
    exp_q.push_back(8'h77);
    do_wr(8'h77);
    chk("fp_accept", {cpu_if.full, cpu_if.overflow}, 2'b10);
    drain();
    chk("fp_frames", frames - fr0, 6);
    if (fall_q.size() > 1) chk("fp_second_fall", fall_q[1] - w, 42);
    chk("fp_no_ovf", cpu_if.overflow, 0);

    // Reset during data bit 3 of 0xA5 (bit 3 is 0)
    do_wr(8'hA5);
    w = last_wr_cyc;
    wait_cyc(w + 1 + 17);
    chk("mid_tx_bit3", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {tx, cpu_if.busy, cpu_if.full, cpu_if.overflow}, 4'b1000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_idle", {tx, cpu_if.busy}, 2'b10);
    fr0 = frames;
    exp_q.push_back(8'hFF);
    do_wr(8'hFF);
    drain();
    chk("mid_rst_frames", frames - fr0, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
